// File: rtl/decode_pkg.sv
// Shared definitions for the decode scheduler and its decoder: FSM encoding,
// stream field widths, END marker and the saturating byte-count helper.
package decode_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    FIN   = 3'd4,
    ABORT = 3'd5
  } state_t;

  localparam int WIN_W = 13;
  localparam int WID_W = 4;
  localparam int LEN_W = 16;
  localparam logic [8:0] END_MARK = 9'b110000000;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] a, input logic inc);
    if (inc && (a != {LEN_W{1'b1}})) return a + LEN_W'(1);
    return a;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin search: grants the first requester after 'last',
// wrapping from NCH-1 back to 0.
module rr_arb #(
  parameter int NCH = 4,
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [LW-1:0]  last,
  output logic [NCH-1:0] grant
);

  logic          w_found;
  logic [LW-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = LW'((int'(last) + i) % NCH);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_sched.sv
// Schedules compressed jobs from NCH channels onto one shared decoder:
// round-robin grant, stream routing, byte counting and an idle watchdog.
module decode_sched
  import decode_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TMO = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [WIN_W*NCH-1:0] ch_stream_data,
  input  logic [NCH-1:0]       ch_stream_valid,
  output logic [NCH-1:0]       ch_stream_ack,
  output logic [WID_W-1:0]     ch_stream_width,
  output logic [WIN_W-1:0]     dec_stream_data,
  output logic                 dec_stream_valid,
  input  logic                 dec_stream_ack,
  input  logic [WID_W-1:0]     dec_stream_width,
  input  logic                 dec_out_valid,
  input  logic                 dec_out_done,
  output logic                 dec_start,
  output logic [NCH-1:0]       gnt,
  output logic [NCH-1:0]       done,
  output logic [LEN_W-1:0]     done_len,
  output logic                 done_err,
  output logic                 busy
);

  localparam int LW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WD_W = $clog2(TMO + 1);

  state_t           r_state;
  logic [NCH-1:0]   r_gnt;
  logic [NCH-1:0]   r_done;
  logic [LW-1:0]    r_last;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_done_len;
  logic             r_done_err;
  logic             r_dec_start;
  logic             r_busy;
  logic [WD_W-1:0]  r_wdog;

  logic [NCH-1:0]   w_win;
  logic [LW-1:0]    w_win_idx;
  logic [WD_W-1:0]  w_wd_next;
  logic             w_prog;

  rr_arb #(.NCH(NCH)) u_arb (
    .req   (req),
    .last  (r_last),
    .grant (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int n = 0; n < NCH; n++)
      if (w_win[n]) w_win_idx = LW'(n);
  end

  assign w_prog    = dec_stream_ack | dec_out_valid;
  assign w_wd_next = r_wdog + WD_W'(1);

  // Winner is latched on leaving IDLE so a request dropping during ARB cannot lose it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_last      <= LW'(NCH - 1);
      r_cnt       <= '0;
      r_done_len  <= '0;
      r_done_err  <= 1'b0;
      r_dec_start <= 1'b0;
      r_busy      <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_done      <= '0;
      r_done_err  <= 1'b0;
      r_dec_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state <= ARB;
            r_gnt   <= w_win;
            r_last  <= w_win_idx;
            r_busy  <= 1'b1;
          end
        end
        ARB: begin
          r_state     <= START;
          r_dec_start <= 1'b1;
        end
        START: begin
          r_cnt   <= '0;
          r_wdog  <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (dec_out_done) begin
            r_state    <= FIN;
            r_done     <= r_gnt;
            r_done_len <= sat_inc(r_cnt, dec_out_valid);
          end else if (w_prog) begin
            r_wdog <= '0;
            r_cnt  <= sat_inc(r_cnt, dec_out_valid);
          end else if (w_wd_next == WD_W'(TMO)) begin
            r_state     <= ABORT;
            r_done      <= r_gnt;
            r_done_len  <= r_cnt;
            r_done_err  <= 1'b1;
            r_dec_start <= 1'b1;
          end else begin
            r_wdog <= w_wd_next;
          end
        end
        FIN, ABORT: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stream crossbar is live only while a job runs
  always_comb begin
    dec_stream_data  = '0;
    dec_stream_valid = 1'b0;
    ch_stream_ack    = '0;
    ch_stream_width  = '0;
    if (r_state == RUN) begin
      ch_stream_width = dec_stream_width;
      for (int n = 0; n < NCH; n++) begin
        if (r_gnt[n]) begin
          dec_stream_data  = ch_stream_data[n*WIN_W +: WIN_W];
          dec_stream_valid = ch_stream_valid[n];
          ch_stream_ack[n] = dec_stream_ack;
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign done_len  = r_done_len;
  assign done_err  = r_done_err;
  assign dec_start = r_dec_start;
  assign busy      = r_busy;

endmodule

// File: tb/tb_decode_sched.sv
// Directed bench for decode_sched: stimulus pushes expected job completions,
// a monitor pops and compares them whenever done pulses.
module tb_decode_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [51:0] ch_stream_data = '0;
  logic [3:0]  ch_stream_valid = '0;
  logic [3:0]  ch_stream_ack;
  logic [3:0]  ch_stream_width;
  logic [12:0] dec_stream_data;
  logic        dec_stream_valid;
  logic        dec_stream_ack = 1'b0;
  logic [3:0]  dec_stream_width = '0;
  logic        dec_out_valid = 1'b0;
  logic        dec_out_done = 1'b0;
  logic        dec_start;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] done_len;
  logic        done_err;
  logic        busy;

  decode_sched #(.NCH(4), .TMO(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .ch_stream_data   (ch_stream_data),
    .ch_stream_valid  (ch_stream_valid),
    .ch_stream_ack    (ch_stream_ack),
    .ch_stream_width  (ch_stream_width),
    .dec_stream_data  (dec_stream_data),
    .dec_stream_valid (dec_stream_valid),
    .dec_stream_ack   (dec_stream_ack),
    .dec_stream_width (dec_stream_width),
    .dec_out_valid    (dec_out_valid),
    .dec_out_done     (dec_out_done),
    .dec_start        (dec_start),
    .gnt              (gnt),
    .done             (done),
    .done_len         (done_len),
    .done_err         (done_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [15:0] len;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done != 4'b0000) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: got done=%b, expected no pulse", done);
      end else begin
        e = q.pop_front();
        chk("done", 32'(done), 32'(e.g));
        chk("done_len", 32'(done_len), 32'(e.len));
        chk("done_err", 32'(done_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dec_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dec_start_wait: got no pulse in 20 cycles, expected one");
    end
  endtask

  task automatic run_job(input logic [3:0] exp_g, input int nbytes, input logic [3:0] req_after);
    bit ok;
    wait_start(ok);
    chk("gnt", 32'(gnt), 32'(exp_g));
    q.push_back('{exp_g, (nbytes > 65535) ? 16'hFFFF : 16'(nbytes), 1'b0});
    tick();
    chk("dec_start_one_cycle", 32'(dec_start), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      dec_out_valid = 1'b1;
      tick();
    end
    dec_out_valid = 1'b0;
    dec_out_done  = 1'b1;
    req           = req_after;
    tick();
    dec_out_done  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bit ok;
    int c;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_len", 32'(done_len), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);
    chk("rst_dec_start", 32'(dec_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Single job on channel 0, 5 bytes
    req = 4'b0001;
    run_job(4'b0001, 5, 4'b0000);

    // Fairness from a fresh reset, then a sparse request pattern
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 8; j++)
      run_job(4'(1 << (j % 4)), j + 1, (j == 7) ? 4'b1010 : 4'b1111);
    run_job(4'b0010, 2, 4'b1010);
    run_job(4'b1000, 2, 4'b1010);
    run_job(4'b0010, 2, 4'b0000);

    // Routing on channel 2
    req = 4'b0100;
    wait_start(ok);
    chk("route_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    q.push_back('{4'b0100, 16'd1, 1'b0});
    ch_stream_data   = {13'h0F44, 13'h1333, 13'h0A22, 13'h0111};
    ch_stream_valid  = 4'b0100;
    dec_stream_ack   = 1'b1;
    dec_stream_width = 4'd5;
    #1;
    chk("pre_run_valid", 32'(dec_stream_valid), 32'd0);
    chk("pre_run_ack", 32'(ch_stream_ack), 32'd0);
    chk("pre_run_width", 32'(ch_stream_width), 32'd0);
    tick();
    chk("route_data", 32'(dec_stream_data), 32'h1333);
    chk("route_valid", 32'(dec_stream_valid), 32'd1);
    chk("route_ack", 32'(ch_stream_ack), 32'b0100);
    chk("route_width", 32'(ch_stream_width), 32'd5);
    ch_stream_valid = 4'b1011;
    dec_stream_ack  = 1'b0;
    #1;
    chk("route_valid_low", 32'(dec_stream_valid), 32'd0);
    chk("route_ack_low", 32'(ch_stream_ack), 32'd0);
    dec_out_valid = 1'b1;
    dec_out_done  = 1'b1;
    tick();
    dec_out_valid = 1'b0;
    dec_out_done  = 1'b0;
    dec_stream_width = 4'd0;
    ch_stream_valid  = 4'b0000;
    tick();

    // Watchdog abort after 3 bytes
    req = 4'b0001;
    wait_start(ok);
    chk("wd_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    q.push_back('{4'b0001, 16'd3, 1'b1});
    tick();
    for (int i = 0; i < 3; i++) begin
      dec_out_valid = 1'b1;
      tick();
    end
    dec_out_valid = 1'b0;
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (dec_start) begin
        c = k;
        break;
      end
    end
    chk("wd_abort_cycle", 32'(c), 32'd16);
    tick();
    chk("wd_busy_after", 32'(busy), 32'd0);

    // Progress exactly on the limit cycle keeps the job alive
    req = 4'b0010;
    wait_start(ok);
    chk("wd2_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    q.push_back('{4'b0010, 16'd1, 1'b0});
    tick();
    dec_out_valid = 1'b1;
    tick();
    dec_out_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    dec_stream_ack = 1'b1;
    tick();
    dec_stream_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("wd2_no_abort_busy", 32'(busy), 32'd1);
    dec_out_done = 1'b1;
    tick();
    dec_out_done = 1'b0;
    tick();

    // Byte counter saturation
    req = 4'b0100;
    run_job(4'b0100, 70000, 4'b0000);

    // Reset in the middle of a running job
    req = 4'b1000;
    wait_start(ok);
    chk("mid_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    tick();
    dec_out_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    dec_stream_ack   = 1'b1;
    dec_stream_width = 4'd7;
    ch_stream_valid  = 4'b1111;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done_len", 32'(done_len), 32'd0);
    chk("mid_rst_ack", 32'(ch_stream_ack), 32'd0);
    chk("mid_rst_valid", 32'(dec_stream_valid), 32'd0);
    chk("mid_rst_width", 32'(ch_stream_width), 32'd0);
    dec_out_valid    = 1'b0;
    dec_stream_ack   = 1'b0;
    dec_stream_width = 4'd0;
    ch_stream_valid  = 4'b0000;
    rst = 1'b1;
    req = 4'b1111;
    run_job(4'b0001, 1, 4'b0000);

    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_sched.md
DECODE_SCHED -- requirements
Module: decode_sched

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels.
REQ-002 Parameter TMO, default 1024: watchdog limit in idle cycles; minimum 2.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req  in  NCH  channel n has a compressed job ready.
REQ-006 ch_stream_data  in  13*NCH  per-channel bitstream window; channel n occupies bits 13n+12:13n.
REQ-007 ch_stream_valid  in  NCH  per-channel window valid.
REQ-008 ch_stream_ack  out  NCH  per-channel consume strobe.
REQ-009 ch_stream_width  out  4  bits consumed; broadcast to all channels.
REQ-010 dec_stream_data  out  13  window to decoder.
REQ-011 dec_stream_valid  out  1  window valid to decoder.
REQ-012 dec_stream_ack  in  1  decoder consume strobe.
REQ-013 dec_stream_width  in  4  decoder consume width.
REQ-014 dec_out_valid  in  1  decoder emitted one byte.
REQ-015 dec_out_done  in  1  decoder reached END marker.
REQ-016 dec_start  out  1  one-cycle decoder restart pulse.
REQ-017 gnt  out  NCH  one-hot grant; held for the whole job.
REQ-018 done  out  NCH  one-cycle job-complete pulse, one-hot.
REQ-019 done_len  out  16  byte count of the completed job; valid with done.
REQ-020 done_err  out  1  completed job was aborted by the watchdog; valid with done.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, ARB, START, RUN, FIN, ABORT.
REQ-023 IDLE: go to ARB when |req is 1, else stay.
- ARB: one cycle; latch the winner into gnt; go to START.
- START: dec_start = 1 for exactly this cycle; clear byte and watchdog counters; go to RUN.
- RUN: FIN on dec_out_done; otherwise ABORT when the watchdog reaches TMO.
- FIN and ABORT: one cycle each; pulse done[granted channel]; then IDLE with gnt cleared.
REQ-024 Arbitration: round-robin; search starts at the channel after the last granted one and wraps NCH-1 to 0.
- After reset, channel 0 has top priority.
- If req falls during ARB, the latched winner still runs.
REQ-025 Grant to complete idle-to-idle spacing: minimum one IDLE cycle between consecutive jobs.
REQ-026 Routing in RUN only, combinational, zero latency, for granted channel g:
- dec_stream_data = ch_stream_data[g]
- dec_stream_valid = ch_stream_valid[g]
- ch_stream_ack[g] = dec_stream_ack
- ch_stream_width = dec_stream_width
REQ-027 Outside RUN, dec_stream_valid, all ch_stream_ack and ch_stream_width are 0. Non-granted acks are always 0.
REQ-028 Byte counter: +1 per dec_out_valid in RUN; 16-bit; saturates at 0xFFFF with no wrap.
- In FIN, the byte counter plus a dec_out_valid on the same cycle as dec_out_done is included in done_len.
REQ-029 Watchdog: clears on any RUN cycle with dec_stream_ack or dec_out_valid, else increments.
- Reaching TMO gives ABORT. Progress on the TMO cycle clears the counter and prevents ABORT.
REQ-030 FIN: done_err = 0. ABORT: done_err = 1, done_len = bytes emitted so far, and dec_start pulses again to flush the decoder.
REQ-031 dec_out_done and dec_out_valid outside RUN are ignored.
REQ-032 A req held high after done re-enters arbitration; it wins again only if no other channel is requesting.

Reset
REQ-033 On rst = 0 at a clock edge, the following return to initial values: state = IDLE, gnt = 0, done = 0, done_err = 0, done_len = 0, dec_start = 0, busy = 0, counters = 0, RR pointer set so that channel 0 has top priority.
REQ-034 Reset asserted mid-job abandons the job silently, with no done pulse. The first post-reset job issues dec_start normally.

Structure
REQ-035 Shared package decode_pkg holds:
- the FSM state encoding
- the stream window width (13)
- the width field size (4)
- the done_len width (16)
- the END marker pattern (9'b110000000), shared with the decoder
REQ-036 The round-robin search is one sub-module, rr_arb, with ports (req, last, grant one-hot), purely combinational; NCH is its parameter.

Verification
REQ-037 Single job: req = 0001; the decoder emits 5 bytes then done -> gnt = 0001 from ARB, dec_start is one cycle, done = 0001 with done_len = 5, done_err = 0.
REQ-038 Fairness: req = 1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3. Then req = 1010 after the last grant 3 -> grant order 1,3,1.
REQ-039 Routing: granted channel 2; drive distinct data on all four channels -> the decoder sees channel 2 data only, ch_stream_ack = 0100 on dec_stream_ack, all other acks 0.
REQ-040 Watchdog: TMO = 16; the decoder stalls after 3 bytes -> ABORT 16 cycles after the last progress, done_err = 1, done_len = 3, second dec_start pulse. Progress at cycle 15 -> no abort.
REQ-041 Saturation and reset: 70000 bytes -> done_len = 0xFFFF. rst low mid-RUN -> all outputs 0 next cycle, no done pulse, next grant to channel 0.
